// File: rtl/de_ctrl_pkg.sv
// Shared types and constants for the Decode/Execute hazard controller.
package de_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        RECOVER  = 2'd2
    } ctrlState_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // $zero is hard-wired, so a dependency through it is never real.
    function automatic logic regMatch(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/de_forward_unit.sv
// Combinational forwarding selects for the Execute ALU inputs and the Decode branch comparator.
module de_forward_unit
    import de_ctrl_pkg::*;
(
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       ForwardAD,
    output logic       ForwardBD
);

    // Memory stage holds the younger result, so it wins over Writeback.
    function automatic logic [1:0] selE(input logic [4:0] src, input logic wrM,
                                        input logic [4:0] dstM, input logic wrW,
                                        input logic [4:0] dstW);
        if (wrM && regMatch(dstM, src))
            return FWD_M;
        else if (wrW && regMatch(dstW, src))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        ForwardAE = selE(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
        ForwardBE = selE(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
        ForwardAD = RegWriteM && regMatch(WriteRegM, RsD);
        ForwardBD = RegWriteM && regMatch(WriteRegM, RtD);
    end

endmodule

// File: rtl/de_hazard_ctrl.sv
// Hazard detection, memory-wait sequencing and stall/flush statistics for the five-stage core.
// state    | meaning
// RUN      | normal flow; load-use and branch hazards stall F/D and bubble E
// MEM_WAIT | Memory access outstanding; whole pipeline frozen, wait timer running
// RECOVER  | access timed out; one cycle of MemTimeout with E flushed
module de_hazard_ctrl
    import de_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             CLK_DReg,
    input  logic             RST_DReg,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic [4:0]       WriteRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic             BranchTakenD,
    input  logic             MemReqM,
    input  logic             MemAckM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    // Down-counter loaded on entry; expiry at zero gives MEM_TIMEOUT wait cycles.
    localparam logic [15:0] WAIT_LOAD = 16'(MEM_TIMEOUT - 1);

    ctrlState_t  state;
    logic [15:0] waitCnt;
    logic        lwStall;
    logic        brStall;
    logic        hazard;
    logic        memEnter;
    logic [1:0]  fwdAE;
    logic [1:0]  fwdBE;
    logic        fwdAD;
    logic        fwdBD;

    de_forward_unit uForward (
        .RsD       (RsD),
        .RtD       (RtD),
        .RsE       (RsE),
        .RtE       (RtE),
        .WriteRegM (WriteRegM),
        .WriteRegW (WriteRegW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardAE (fwdAE),
        .ForwardBE (fwdBE),
        .ForwardAD (fwdAD),
        .ForwardBD (fwdBD)
    );

    assign lwStall  = MemtoRegE && (regMatch(RtE, RsD) || regMatch(RtE, RtD));
    assign brStall  = BranchD &&
                      ((RegWriteE && (regMatch(WriteRegE, RsD) || regMatch(WriteRegE, RtD))) ||
                       (MemtoRegM && (regMatch(WriteRegM, RsD) || regMatch(WriteRegM, RtD))));
    assign hazard   = lwStall || brStall;
    assign memEnter = (state == RUN) && MemReqM && !MemAckM;

    // Every output, combinational or not, is held low while reset is asserted.
    assign ForwardAE = RST_DReg ? fwdAE : FWD_RF;
    assign ForwardBE = RST_DReg ? fwdBE : FWD_RF;
    assign ForwardAD = RST_DReg && fwdAD;
    assign ForwardBD = RST_DReg && fwdBD;

    always_comb begin
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        MemTimeout = 1'b0;
        if (RST_DReg) begin
            case (state)
                RUN: begin
                    if (memEnter) begin
                        {StallF, StallD, StallE, StallM} = 4'b1111;
                    end else begin
                        StallF = hazard;
                        StallD = hazard;
                        FlushE = hazard;
                        FlushD = BranchTakenD && !hazard;
                    end
                end
                MEM_WAIT: {StallF, StallD, StallE, StallM} = 4'b1111;
                RECOVER: begin
                    StallF     = 1'b1;
                    StallD     = 1'b1;
                    FlushE     = 1'b1;
                    MemTimeout = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_DReg or negedge RST_DReg) begin
        if (!RST_DReg) begin
            state    <= RUN;
            waitCnt  <= '0;
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (memEnter) begin
                        state   <= MEM_WAIT;
                        waitCnt <= WAIT_LOAD;
                    end
                end
                MEM_WAIT: begin
                    if (MemAckM)
                        state <= RUN;
                    else if (waitCnt == '0)
                        state <= RECOVER;
                    else
                        waitCnt <= waitCnt - 16'd1;
                end
                RECOVER: state <= RUN;
                default: state <= RUN;
            endcase
            if (StallD && (StallCnt != '1))
                StallCnt <= StallCnt + CNT_W'(1);
            if ((FlushD || FlushE) && (FlushCnt != '1))
                FlushCnt <= FlushCnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/de_hazard_ctrl.md
# de_hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage MIPS core; it owns the clear input of the Decode/Execute pipeline register and the stall/flush controls of the neighbouring stages. It detects load-use and branch-operand hazards, generates forwarding selects for Decode and Execute, freezes the pipeline while a Memory-stage access is outstanding (with timeout recovery), and keeps saturating stall/flush statistics counters.

## Interface
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before forced recovery (1..65535)
- CNT_W, 16: width of statistics counters
- CLK_DReg  in  1  clock, rising edge
- RST_DReg  in  1  asynchronous, active-low reset
- RsD, RtD  in  5  source registers of instruction in Decode
- RsE, RtE  in  5  source registers of instruction in Execute
- WriteRegE, WriteRegM, WriteRegW  in  5  destination register per stage
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enable per stage
- MemtoRegE, MemtoRegM  in  1  load instruction in E / M
- BranchD  in  1  branch in Decode; BranchTakenD  in  1  branch resolved taken
- MemReqM  in  1  Memory stage access pending; MemAckM  in  1  access complete
- StallF, StallD, StallE, StallM  out  1  hold stage register
- FlushD  out  1  clear Fetch/Decode register; FlushE  out  1  drives CLR_DReg
- ForwardAE, ForwardBE  out  2  00 regfile, 01 from W, 10 from M
- ForwardAD, ForwardBD  out  1  forward ALUOutM into Decode comparator
- MemTimeout  out  1  one-cycle pulse on timeout
- StallCnt, FlushCnt  out  CNT_W  saturating statistics

## Operation
- Register 0 never matches in any comparison below.
- ForwardAE = 10 if RegWriteM and WriteRegM==RsE; else 01 if RegWriteW and WriteRegW==RsE; else 00. ForwardBE identical using RtE. M has priority over W.
- ForwardAD = RegWriteM and WriteRegM==RsD; ForwardBD same for RtD.
- lwstall = MemtoRegE and (RtE==RsD or RtE==RtD).
- brstall = BranchD and ((RegWriteE and WriteRegE in {RsD,RtD}) or (MemtoRegM and WriteRegM in {RsD,RtD})).
- FSM states: RUN, MEM_WAIT, RECOVER.
  - RUN: if MemReqM and not MemAckM -> MEM_WAIT, wait counter cleared. Otherwise: hazard = lwstall or brstall; StallF=StallD=FlushE=hazard; FlushD = BranchTakenD and not hazard.
  - MEM_WAIT: StallF=StallD=StallE=StallM=1, FlushD=FlushE=0, hazard logic masked. MemAckM=1 -> RUN. Counter reaching MEM_TIMEOUT-1 without ack -> RECOVER.
  - RECOVER: MemTimeout=1, FlushE=1, StallF=StallD=1; unconditional -> RUN.
- MemAckM taking precedence over timeout in the same cycle.
- StallCnt increments each cycle StallD=1; FlushCnt increments each cycle FlushD or FlushE=1; both saturate at all-ones, never wrap.

## Timing
- Stall, flush and forward outputs are combinational from current inputs and registered state (same-cycle effect on the stage registers at the next edge).
- FSM state, wait counter, StallCnt, FlushCnt are registered on CLK_DReg.
- Reset (RST_DReg low, asynchronous): state RUN, counters 0; all outputs forced 0 while reset is asserted, including combinational ones.
- Reset during MEM_WAIT: immediate return to RUN, no MemTimeout pulse.
- Load-use stall costs exactly one bubble: with lwstall in cycle n, FlushE=1 in n, load leaves E at n+1 and lwstall drops.
- Branch stall lasts 1 cycle (producer in E, ALU) or 2 cycles (producer is load).
- Memory entry latency: MEM_WAIT entered the edge after MemReqM=1 & MemAckM=0 seen in RUN; that first cycle also stalls (stall asserted combinationally from RUN when condition true).

## Structure
- Package de_ctrl_pkg: state enum (RUN, MEM_WAIT, RECOVER), forward-select constants FWD_RF=00, FWD_W=01, FWD_M=10.
- One sub-module natural: de_forward_unit (pure combinational forwarding selects); FSM, hazard detection and counters stay in the top.

## Test plan
- RegWriteM=1, WriteRegM=8, RsE=8, RegWriteW=1, WriteRegW=8 -> ForwardAE=10; WriteRegM=0, RsE=0 -> ForwardAE=00.
- lw $9 in E (MemtoRegE=1, RtE=9), RsD=9 -> StallF=StallD=FlushE=1 for one cycle, StallCnt=1.
- BranchD=1, RsD=4, load to $4 in E then M -> brstall two consecutive cycles; then BranchTakenD=1 -> FlushD=1 one cycle.
- MemReqM=1, MemAckM held 0, MEM_TIMEOUT=4 -> all four stalls for 4 cycles, MemTimeout pulse one cycle, back to RUN; ack on cycle 3 instead -> no pulse.
- Drop RST_DReg mid MEM_WAIT -> all outputs 0 immediately, state RUN after release.
- Hold lwstall for 2^CNT_W+5 cycles (CNT_W=4) -> StallCnt saturates at 15.
